// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Mode enum, mode encodings and divisor floor shared by clk_en_divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package clk_div_pkg;

  localparam int MIN_DIV = 2;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_HALT = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  typedef enum logic [1:0] {
    CLK_RUN  = MODE_RUN,
    CLK_HALT = MODE_HALT,
    CLK_STEP = MODE_STEP
  } clk_mode_t;

endpackage

`default_nettype wire

// File: rtl/clk_div_channel.sv
// ============================================================================
// Module   : clk_div_channel
// Brief    : One divider channel: divisor register, wrap counter, enable pulse and square wave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             step_mode_i,
  input  logic             step_pulse_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             en_o,
  output logic             clk_o
);

  localparam logic [WIDTH-1:0] RST_DIV =
    (DEFAULT_DIV < MIN_DIV) ? WIDTH'(MIN_DIV) : WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             clk_q, clk_d;
  logic             w_term;

  assign w_term = (cnt_q == div_q - WIDTH'(1));

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    en_d  = 1'b0;
    clk_d = clk_q;
    if (run_i) begin
      cnt_d = w_term ? '0 : cnt_q + WIDTH'(1);
      en_d  = w_term & ~we_i;
      clk_d = (cnt_q >= div_q - (div_q >> 1));
    end else if (step_mode_i) begin
      en_d  = step_pulse_i;
      clk_d = step_pulse_i;
    end
    // A write restarts the period from zero regardless of mode.
    if (we_i) begin
      div_d = (div_i < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : div_i;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= RST_DIV;
      cnt_q <= '0;
      en_q  <= 1'b0;
      clk_q <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      en_q  <= en_d;
      clk_q <= clk_d;
    end
  end

  assign en_o  = en_q;
  assign clk_o = clk_q;

endmodule

`default_nettype wire

// File: rtl/clk_en_divider.sv
// ============================================================================
// Module   : clk_en_divider
// Brief    : CH-channel programmable clock-enable generator with run/halt/step.
//            Define CLK_EN_DIVIDER_STEP_EN to compile in single-step support.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_en_divider
  import clk_div_pkg::*;
#(
  parameter int CH          = 2,
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 100_000_000
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_we,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
  input  logic [WIDTH-1:0]                       cfg_div,
  input  logic [1:0]                             mode,
  input  logic                                   step_req,
  output logic [CH-1:0]                          en_o,
  output logic [CH-1:0]                          clk_o
);

  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  clk_mode_t w_mode;
  logic      w_run;
  logic      w_step_mode;
  logic      w_step_rise;

  always_comb begin
    w_mode = CLK_HALT;
    case (mode)
      MODE_RUN:  w_mode = CLK_RUN;
`ifdef CLK_EN_DIVIDER_STEP_EN
      MODE_STEP: w_mode = CLK_STEP;
`endif
      default:   w_mode = CLK_HALT;
    endcase
  end

  assign w_run       = (w_mode == CLK_RUN);
  assign w_step_mode = (w_mode == CLK_STEP);

`ifdef CLK_EN_DIVIDER_STEP_EN
  logic step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step_req;
  end

  assign w_step_rise = step_req & ~step_q;
`else
  logic w_unused_step;

  assign w_unused_step = step_req;
  assign w_step_rise   = 1'b0;
`endif

  generate
    for (genvar i = 0; i < CH; i++) begin : g_ch
      clk_div_channel #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .clk          (clk),
        .rst          (rst),
        .run_i        (w_run),
        .step_mode_i  (w_step_mode),
        .step_pulse_i (w_step_rise),
        .we_i         (cfg_we && (cfg_ch == CHW'(i))),
        .div_i        (cfg_div),
        .en_o         (en_o[i]),
        .clk_o        (clk_o[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clk_en_divider.sv
// ============================================================================
// Module   : tb_clk_en_divider
// Brief    : Self-checking bench for clk_en_divider with a behavioural period model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clk_en_divider;

  localparam int CH    = 3;
  localparam int WIDTH = 16;
  localparam int DDIV  = 4;
  localparam int CHW   = 2;
`ifdef CLK_EN_DIVIDER_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic [1:0]       mode;
  logic             step_req;
  logic [CH-1:0]    en_o;
  logic [CH-1:0]    clk_o;

  clk_en_divider #(
    .CH          (CH),
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .mode     (mode),
    .step_req (step_req),
    .en_o     (en_o),
    .clk_o    (clk_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: per channel, number of RUN edges since the last clear and the period.
  int            runs [CH];
  int            dv   [CH];
  logic [CH-1:0] exp_en;
  logic [CH-1:0] exp_clk;
  bit            prev_step;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      runs[c] = 0;
      dv[c]   = DDIV;
    end
    exp_en    = '0;
    exp_clk   = '0;
    prev_step = 1'b0;
  endtask

  task automatic model_edge();
    bit run, stp, rise;
    run  = (mode == 2'b00);
    stp  = STEP_EN && (mode == 2'b10);
    rise = STEP_EN && step_req && !prev_step;
    prev_step = step_req;
    for (int c = 0; c < CH; c++) begin
      bit wr;
      int ph;
      wr = cfg_we && (int'(cfg_ch) == c);
      if (run) begin
        ph         = runs[c] % dv[c];
        exp_en[c]  = (ph == dv[c] - 1) && !wr;
        exp_clk[c] = (ph >= dv[c] - dv[c] / 2);
        runs[c]++;
      end else if (stp) begin
        exp_en[c]  = rise;
        exp_clk[c] = rise;
      end else begin
        exp_en[c] = 1'b0;
      end
      if (wr) begin
        dv[c]   = (cfg_div < 2) ? 2 : int'(cfg_div);
        runs[c] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("en_o", 32'(en_o), 32'(exp_en));
    check_eq("clk_o", 32'(clk_o), 32'(exp_clk));
  endtask

  task automatic write_div(input int ch, input int d);
    cfg_we  = 1'b1;
    cfg_ch  = CHW'(ch);
    cfg_div = WIDTH'(d);
    tick();
    cfg_we  = 1'b0;
  endtask

  initial begin
    int n, prev, cnt_hi;
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; mode = 2'b00; step_req = 1'b0;
    model_reset();
    #1;
    check_eq("rst_en", 32'(en_o), 32'd0);
    check_eq("rst_clk", 32'(clk_o), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Default divisor 4: pulses on cycles 4, 8, 12 and clk 0,0,1,1.
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_eq("tp1_en0", 32'(en_o[0]), 32'((k % 4) == 0));
      check_eq("tp1_clk0", 32'(clk_o[0]), 32'(((k - 1) % 4) >= 2));
    end

    // D=5 on channel 1 while channel 0 keeps running at 4.
    write_div(1, 5);
    cnt_hi = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      cnt_hi += int'(clk_o[1]);
    end
    check_eq("tp2_hi_d5", 32'(cnt_hi), 32'd4);

    // D=0 and D=1 both behave as D=2.
    for (int v = 0; v < 2; v++) begin
      write_div(0, v);
      n = 0; prev = 0; cnt_hi = 0;
      for (int k = 0; k < 6; k++) begin
        tick();
        n += int'(en_o[0]);
        if (prev == 1 && en_o[0] == 1'b1) cnt_hi++;
        prev = int'(en_o[0]);
      end
      check_eq("tp3_pulses", 32'(n), 32'd3);
      check_eq("tp3_back2back", 32'(cnt_hi), 32'd0);
    end

    // D=8, halt at cnt=3 for 10 cycles, resume: pulse 5 cycles later.
    write_div(0, 8);
    repeat (3) tick();
    mode = 2'b01;
    n = 0;
    repeat (10) begin
      tick();
      n += int'(en_o[0]);
    end
    check_eq("tp4_halt_pulses", 32'(n), 32'd0);
    mode = 2'b00;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (en_o[0]) begin
        n = k;
        break;
      end
    end
    check_eq("tp4_resume", 32'(n), 32'd5);

    // Step mode: high x3, low, high, low x2.
    mode = 2'b10; step_req = 1'b0;
    repeat (2) tick();
    n = 0;
    for (int k = 0; k < 7; k++) begin
      step_req = (k < 3 || k == 4);
      tick();
      if (en_o == '1 && clk_o == '1) n++;
    end
    step_req = 1'b0;
    check_eq("tp5_step_pulses", 32'(n), STEP_EN ? 32'd2 : 32'd0);

    // Randomized traffic, including ignored channel index 3.
    for (int k = 0; k < 1500; k++) begin
      mode     = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
      cfg_we   = ($urandom_range(0, 15) == 0);
      cfg_ch   = CHW'($urandom_range(0, 3));
      cfg_div  = WIDTH'($urandom_range(0, 9));
      step_req = 1'($urandom_range(0, 1));
      tick();
    end
    cfg_we = 1'b0; step_req = 1'b0; mode = 2'b00;
    repeat (3) tick();

    // Async reset mid-period with a write pending.
    @(posedge clk);
    #3;
    cfg_we = 1'b1; cfg_ch = '0; cfg_div = WIDTH'(7);
    rst = 1'b1;
    #1;
    check_eq("tp6_async_en", 32'(en_o), 32'd0);
    check_eq("tp6_async_clk", 32'(clk_o), 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    cfg_we = 1'b0;
    rst = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (en_o[0]) begin
        n = k;
        break;
      end
    end
    check_eq("tp6_first_pulse", 32'(n), 32'(DDIV));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
